// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM state encodings, error codes,
// the default start-of-frame byte and the modular checksum helper.
package uart_frame_parser_pkg;

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] LEN     = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] CSUM    = 2'd3;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE = 2'b00;
    localparam err_code_t ERR_LEN  = 2'b01;
    localparam err_code_t ERR_CSUM = 2'b10;
    localparam err_code_t ERR_TMO  = 2'b11;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

    // LEN, payload and CSUM bytes must sum to zero modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte idle counter: counts enabled cycles and pulses expired combinationally
// on the TIMEOUT-th consecutive enabled cycle since the last clear.
module uart_timeout_cnt #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count_reg;

    assign expired = en && (count_reg == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr || expired) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Pops bytes from the rx FIFO, hunts for SOF, validates LEN and checksum and streams
// payload bytes on a valid/ready port with per-frame ok/err pulses.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter int         DBIT    = 8,
    parameter logic [7:0] SOF     = DEFAULT_SOF,
    parameter int         MAX_LEN = 64,
    parameter int         TIMEOUT = 50000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd_uart,
    output logic [DBIT-1:0] pl_data,
    output logic            pl_valid,
    input  logic            pl_ready,
    output logic            pl_last,
    output logic            frame_ok,
    output logic            frame_err,
    output logic [1:0]      err_code,
    output logic [7:0]      drop_cnt
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    logic [1:0]      state_reg;
    logic [7:0]      acc_reg;
    logic [7:0]      cnt_reg;
    logic [DBIT-1:0] pl_data_reg;
    logic            pl_valid_reg;
    logic            pl_last_reg;
    logic            frame_ok_reg;
    logic            frame_err_reg;
    err_code_t       err_code_reg;
    logic [7:0]      drop_cnt_reg;

    logic       pl_free;
    logic       in_frame;
    logic       tmo_en;
    logic       tmo_clr;
    logic       tmo_expired;
    logic [7:0] rx_byte;
    logic       len_bad;
    logic       csum_good;

    assign rx_byte   = r_data[7:0];
    assign pl_free   = !pl_valid_reg || pl_ready;
    assign in_frame  = (state_reg != HUNT);
    assign len_bad   = (rx_byte == 8'h00) || (rx_byte > MAX_LEN_B);
    assign csum_good = (csum_add(acc_reg, rx_byte) == 8'h00);

    // Payload and checksum pops wait for the output register, so the verdict never
    // overtakes the last payload byte.
    always_comb begin
        rd_uart = 1'b0;
        case (state_reg)
            HUNT, LEN:     rd_uart = !rx_empty;
            PAYLOAD, CSUM: rd_uart = !rx_empty && pl_free;
            default:       rd_uart = 1'b0;
        endcase
    end

    // Only starvation counts; backpressure with data waiting does not.
    assign tmo_en  = in_frame && rx_empty;
    assign tmo_clr = rd_uart || !in_frame;

    uart_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= HUNT;
            acc_reg       <= 8'h00;
            cnt_reg       <= 8'h00;
            pl_data_reg   <= '0;
            pl_valid_reg  <= 1'b0;
            pl_last_reg   <= 1'b0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
            drop_cnt_reg  <= 8'h00;
        end else begin
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (pl_valid_reg && pl_ready) begin
                pl_valid_reg <= 1'b0;
                pl_last_reg  <= 1'b0;
            end
            case (state_reg)
                HUNT: begin
                    if (rd_uart) begin
                        if (rx_byte == SOF) begin
                            state_reg <= LEN;
                        end else if (drop_cnt_reg != 8'hFF) begin
                            drop_cnt_reg <= drop_cnt_reg + 8'd1;
                        end
                    end
                end
                LEN: begin
                    if (tmo_expired) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TMO;
                        state_reg     <= HUNT;
                    end else if (rd_uart) begin
                        acc_reg <= rx_byte;
                        cnt_reg <= rx_byte;
                        if (len_bad) begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LEN;
                            state_reg     <= HUNT;
                        end else begin
                            state_reg <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (tmo_expired) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TMO;
                        state_reg     <= HUNT;
                    end else if (rd_uart) begin
                        pl_data_reg  <= r_data;
                        pl_valid_reg <= 1'b1;
                        pl_last_reg  <= (cnt_reg == 8'd1);
                        acc_reg      <= csum_add(acc_reg, rx_byte);
                        cnt_reg      <= cnt_reg - 8'd1;
                        if (cnt_reg == 8'd1) begin
                            state_reg <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (tmo_expired) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TMO;
                        state_reg     <= HUNT;
                    end else if (rd_uart) begin
                        if (csum_good) begin
                            frame_ok_reg <= 1'b1;
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_CSUM;
                        end
                        state_reg <= HUNT;
                    end
                end
                default: state_reg <= HUNT;
            endcase
        end
    end

    assign pl_data   = pl_data_reg;
    assign pl_valid  = pl_valid_reg;
    assign pl_last   = pl_last_reg;
    assign frame_ok  = frame_ok_reg;
    assign frame_err = frame_err_reg;
    assign err_code  = err_code_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a queue models the FWFT rx FIFO, accepted payload
// bytes and ok/err pulses are collected each cycle and checked with immediate assertions.
module tb_uart_frame_parser;

    localparam int TMO  = 40;
    localparam int MAXL = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       pl_ready = 1'b1;
    logic       rd_uart;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] drop_cnt;

    uart_frame_parser #(
        .DBIT   (8),
        .SOF    (8'hA5),
        .MAX_LEN(MAXL),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .pl_last  (pl_last),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    logic [7:0] got[$];
    logic [7:0] expv[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         last_cnt, last_pos, ok_cnt, err_cnt, valid_seen, order_bad;
    int         both_cnt = 0;
    int         bad_rd = 0;
    int         err_tick, tick_no, base_tick, guard;
    logic [1:0] err_seen;
    bit         last_acc;
    bit         rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        rx_empty = 1'b0;
        r_data   = fifo[0];
    endtask

    task automatic clear_mon();
        got.delete();
        expv.delete();
        last_cnt = 0; last_pos = 0; ok_cnt = 0; err_cnt = 0;
        valid_seen = 0; order_bad = 0; err_seen = 2'b00;
        last_acc = 1'b0; err_tick = -1; tick_no = 0;
    endtask

    // One clock: sample handshakes before the edge, update FIFO model and monitors after it.
    task automatic tick();
        bit         take;
        bit         acc;
        logic [7:0] d;
        logic       l;
        #1;
        take = rd_uart;
        acc  = pl_valid && pl_ready;
        d    = pl_data;
        l    = pl_last;
        if (take && rx_empty) bad_rd++;
        @(posedge clk);
        #1;
        tick_no++;
        if (take && fifo.size() != 0) void'(fifo.pop_front());
        if (acc) begin
            got.push_back(d);
            if (l) begin
                last_cnt++;
                last_pos = got.size();
                last_acc = 1'b1;
            end
        end
        if (frame_ok) begin
            ok_cnt++;
            if (!last_acc) order_bad++;
            last_acc = 1'b0;
        end
        if (frame_err) begin
            err_cnt++;
            err_seen = err_code;
            err_tick = tick_no;
        end
        if (frame_ok && frame_err) both_cnt++;
        if (pl_valid) valid_seen++;
        rx_empty = (fifo.size() == 0);
        r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
        if (rand_ready) pl_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((fifo.size() != 0 || pl_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(tag, fifo.size(), 0);
    endtask

    task automatic tick_until_empty();
        int n = 0;
        while (fifo.size() != 0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] pack_got();
        logic [31:0] p = 32'h0;
        foreach (got[i]) p = {p[23:0], got[i]};
        return p;
    endfunction

    function automatic int payload_mismatch();
        int mm = 0;
        for (int i = 0; i < expv.size(); i++) begin
            if (i >= got.size() || got[i] !== expv[i]) mm++;
        end
        return mm;
    endfunction

    initial begin
        logic [7:0] sum;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pl_valid", pl_valid, 0);
        check("rst_pl_data", pl_data, 0);
        check("rst_pl_last", pl_last, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_rd_uart", rd_uart, 0);
        reset_n = 1'b1;

        // Good frame: 0x03+0x11+0x22+0x33+0x97 = 0x100
        clear_mon();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
        drain("t1_drain", 50);
        check("t1_count", got.size(), 3);
        check("t1_payload", pack_got(), 32'h00112233);
        check("t1_last_cnt", last_cnt, 1);
        check("t1_last_pos", last_pos, 3);
        check("t1_ok", ok_cnt, 1);
        check("t1_err", err_cnt, 0);

        // Same payload, checksum 0x89 leaves 0xF2 -> checksum error, pl_last still seen
        clear_mon();
        push(8'hA5); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h89);
        drain("t1b_drain", 50);
        check("t1b_payload", pack_got(), 32'h00112233);
        check("t1b_ok", ok_cnt, 0);
        check("t1b_err", err_cnt, 1);
        check("t1b_code", err_seen, 2'b10);

        // Bad checksum: 0x02+0x10+0x20+0x00 = 0x32
        clear_mon();
        push(8'hA5); push(8'h02); push(8'h10); push(8'h20); push(8'h00);
        drain("t2_drain", 50);
        check("t2_payload", pack_got(), 32'h00001020);
        check("t2_ok", ok_cnt, 0);
        check("t2_err", err_cnt, 1);
        check("t2_code", err_code, 2'b10);

        // Garbage before SOF, then drop counter saturation
        clear_mon();
        push(8'h00); push(8'hFF); push(8'h5A);
        push(8'hA5); push(8'h01); push(8'h7E); push(8'h81);
        drain("t3_drain", 50);
        check("t3_drop", drop_cnt, 3);
        check("t3_payload", pack_got(), 32'h0000007E);
        check("t3_ok", ok_cnt, 1);
        for (int i = 0; i < 252; i++) push(8'h5A);
        drain("t3_junk1_drain", 400);
        check("t3_drop_255", drop_cnt, 255);
        for (int i = 0; i < 48; i++) push(8'h5A);
        drain("t3_junk2_drain", 100);
        check("t3_drop_sat", drop_cnt, 255);

        // LEN = 0 and LEN = MAX_LEN+1
        clear_mon();
        push(8'hA5); push(8'h00);
        drain("t4a_drain", 20);
        check("t4a_err", err_cnt, 1);
        check("t4a_code", err_seen, 2'b01);
        clear_mon();
        push(8'hA5); push(8'(MAXL + 1));
        drain("t4b_drain", 20);
        check("t4b_err", err_cnt, 1);
        check("t4b_code", err_seen, 2'b01);
        check("t4_no_valid", valid_seen, 0);
        clear_mon();
        push(8'hA5); push(8'h01); push(8'h55); push(8'hAA);
        drain("t4c_drain", 20);
        check("t4c_ok", ok_cnt, 1);
        check("t4c_payload", pack_got(), 32'h00000055);

        // Timeout at exactly TMO idle cycles mid-payload
        clear_mon();
        push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
        tick_until_empty();
        base_tick = tick_no;
        guard = 0;
        while (err_cnt == 0 && guard < TMO + 10) begin
            tick();
            guard++;
        end
        check("t5_tmo_cycle", err_tick - base_tick, TMO);
        check("t5_code", err_seen, 2'b11);
        check("t5_payload", pack_got(), 32'h00000102);
        check("t5_no_last", last_cnt, 0);
        check("t5_ok", ok_cnt, 0);

        // TMO-1 idle cycles before each late byte: no timeout (0x04+1+2+3+4+0xF2 = 0x100)
        clear_mon();
        push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
        tick_until_empty();
        repeat (TMO - 1) tick();
        push(8'h03);
        tick_until_empty();
        repeat (TMO - 1) tick();
        push(8'h04);
        tick_until_empty();
        repeat (TMO - 1) tick();
        push(8'hF2);
        drain("t5b_drain", 20);
        check("t5b_err", err_cnt, 0);
        check("t5b_ok", ok_cnt, 1);
        check("t5b_payload", pack_got(), 32'h01020304);

        // MAX_LEN frame under random backpressure
        clear_mon();
        rand_ready = 1'b1;
        sum = 8'(MAXL);
        push(8'hA5);
        push(8'(MAXL));
        for (int i = 0; i < MAXL; i++) begin
            expv.push_back(8'(i * 7 + 3));
            push(8'(i * 7 + 3));
            sum = sum + 8'(i * 7 + 3);
        end
        push(8'h00 - sum);
        drain("t6a_drain", 2000);
        rand_ready = 1'b0;
        pl_ready = 1'b1;
        check("t6a_count", got.size(), MAXL);
        check("t6a_mismatch", payload_mismatch(), 0);
        check("t6a_last_pos", last_pos, MAXL);
        check("t6a_ok", ok_cnt, 1);
        check("t6a_err", err_cnt, 0);
        check("t6a_order", order_bad, 0);

        // Consumer stalled 100 cycles with data waiting: no timeout, nothing lost
        clear_mon();
        pl_ready = 1'b0;
        sum = 8'h08;
        push(8'hA5);
        push(8'h08);
        for (int i = 0; i < 8; i++) begin
            expv.push_back(8'(8'hC0 + i));
            push(8'(8'hC0 + i));
            sum = sum + 8'(8'hC0 + i);
        end
        push(8'h00 - sum);
        repeat (100) tick();
        check("t6b_stall_err", err_cnt, 0);
        check("t6b_stall_got", got.size(), 0);
        check("t6b_stall_fifo", fifo.size(), 8);
        check("t6b_stall_valid", pl_valid, 1);
        pl_ready = 1'b1;
        drain("t6b_drain", 100);
        check("t6b_count", got.size(), 8);
        check("t6b_mismatch", payload_mismatch(), 0);
        check("t6b_ok", ok_cnt, 1);
        check("t6b_order", order_bad, 0);

        // Reset mid-payload
        clear_mon();
        push(8'hA5); push(8'h05); push(8'h01); push(8'h02); push(8'h03);
        repeat (3) tick();
        check("t7_pre_valid", pl_valid, 1);
        reset_n = 1'b0;
        #1;
        check("t7_pl_valid", pl_valid, 0);
        check("t7_pl_data", pl_data, 0);
        check("t7_pl_last", pl_last, 0);
        check("t7_frame_ok", frame_ok, 0);
        check("t7_frame_err", frame_err, 0);
        check("t7_err_code", err_code, 0);
        check("t7_drop_cnt", drop_cnt, 0);
        fifo.delete();
        rx_empty = 1'b1;
        r_data = 8'h00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_mon();
        push(8'hA5); push(8'h01); push(8'h7E); push(8'h81);
        drain("t7_drain", 20);
        check("t7_after_ok", ok_cnt, 1);
        check("t7_after_err", err_cnt, 0);
        check("t7_after_payload", pack_got(), 32'h0000007E);

        check("both_pulses", both_cnt, 0);
        check("rd_when_empty", bad_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
